// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the word-memory controller and its memory.
//   - default address/data widths (shared with the memory instance)
//   - controller state encoding
//   - request record (wr, addr, wdata)
package mem_pkg;

    localparam int MEM_ADDR_SIZE = 10;
    localparam int MEM_WORD_SIZE = 8;
    localparam int MEM_ERR_CNT_W = 8;

    // VERIFY is only reached when MEM_CTRL_VERIFY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        SAMPLE = 3'd4,
        VERIFY = 3'd5
    } state_t;

    typedef struct packed {
        logic                     wr;
        logic [MEM_ADDR_SIZE-1:0] addr;
        logic [MEM_WORD_SIZE-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: initiator for the asynchronous-write word memory.
// Takes one read/write request at a time over valid/ready, sequences
// cs/wr so that address and data are stable with cs high before wr rises
// and wr falls before cs drops, and returns a one-cycle response pulse.
//
// Optional feature macro: MEM_CTRL_VERIFY_EN
//   Writes read the word back (HOLD -> VERIFY) and flag a mismatch on
//   rsp_err, counted in the saturating err_cnt. Without it both are 0.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_wr/addr/wdata     request fields, latched at acceptance
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             read data, held until the next read completes
//   rsp_err, err_cnt      readback mismatch flag / saturating count
//   mem_addr/din/wr/cs    strobes to the memory
//   mem_dout              combinational read data from the memory
//
// state  | meaning
// IDLE   | ready for a request, cs low
// SETUP  | address/data driven, cs high, wr low
// STROBE | wr high, memory captures the word on its rising edge
// HOLD   | wr low again, cs still high
// SAMPLE | read data settles, captured at the exit edge
// VERIFY | write readback compare (feature builds only)
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_SIZE = MEM_ADDR_SIZE,
    parameter int WORD_SIZE = MEM_WORD_SIZE,
    parameter int ERR_CNT_W = MEM_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_din,
    output logic                 mem_wr,
    output logic                 mem_cs,
    input  logic [WORD_SIZE-1:0] mem_dout
);

    state_t state, state_d;
    logic   wr_q;
    logic   accept;
    logic   done;

    assign accept = req_valid && req_ready;
    assign done   = (state != IDLE) && (state_d == IDLE);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = wr_q ? STROBE : SAMPLE;
            STROBE:  state_d = HOLD;
`ifdef MEM_CTRL_VERIFY_EN
            HOLD:    state_d = VERIFY;
            VERIFY:  state_d = IDLE;
`else
            HOLD:    state_d = IDLE;
`endif
            SAMPLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output is a flop.
    // mem_addr/mem_din double as the latched request fields and therefore
    // only move on acceptance (IDLE -> SETUP).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            req_ready <= 1'b1;
            mem_cs    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_d;
            req_ready <= (state_d == IDLE);
            mem_cs    <= (state_d != IDLE);
            mem_wr    <= (state_d == STROBE);
            rsp_valid <= done;
            if (accept) begin
                wr_q     <= req_wr;
                mem_addr <= req_addr;
                mem_din  <= req_wdata;
            end
            if (state == SAMPLE) rsp_rdata <= mem_dout;
        end
    end

`ifdef MEM_CTRL_VERIFY_EN
    logic mismatch;
    assign mismatch = (state == VERIFY) && (mem_dout != mem_din);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            rsp_err <= mismatch;
            if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign rsp_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
    import mem_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_wr = 1'b0;
    logic [9:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] err_cnt;
    logic [9:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_wr;
    logic       mem_cs;
    logic [7:0] mem_dout;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .err_cnt(err_cnt), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_wr(mem_wr), .mem_cs(mem_cs), .mem_dout(mem_dout)
    );

    // Asynchronous-write memory: word captured on the wr rising edge while
    // cs is high; wmask models stuck-at-0 bits in the cell array.
    logic [7:0] mem [0:1023];
    logic [7:0] wmask = 8'hFF;
    always @(posedge mem_wr) if (mem_cs) mem[mem_addr] = mem_din & wmask;
    assign mem_dout = mem[mem_addr];

`ifdef MEM_CTRL_VERIFY_EN
    localparam int WLAT = 4;
`else
    localparam int WLAT = 3;
`endif
    localparam int RLAT = 2;

    int total = 0;
    int bad = 0;
    int viol = 0;
    logic [7:0] last_rd = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe-ordering monitor.
    logic       p_cs = 1'b0, p_wr = 1'b0, p_rst = 1'b0;
    logic [9:0] p_addr = '0;
    logic [7:0] p_din = '0;
    always @(negedge clk) begin
        if (rst_n && p_rst) begin
            if (mem_wr && !mem_cs) viol++;
            if (mem_wr && !p_cs) viol++;
            if (p_wr && !mem_cs) viol++;
            if ((mem_addr != p_addr || mem_din != p_din) && !(mem_cs && !p_cs)) viol++;
        end
        p_cs = mem_cs; p_wr = mem_wr; p_rst = rst_n;
        p_addr = mem_addr; p_din = mem_din;
    end

    // One transaction; entered and left at posedge+#1. After acceptance the
    // request inputs are scrambled to show the latched values are used.
    task automatic do_req(input string name, input logic wr, input logic [9:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rdata,
                          input logic exp_err);
        int n = 0;
        int lat = 0;
        int wr_cyc = 0;
        logic latch_ok = 1'b1;
        logic fin = 1'b0;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_ready"}, req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata;
        for (int k = 1; k <= 20 && !fin; k++) begin
            if (mem_wr) wr_cyc++;
            if (mem_addr != addr || mem_din != wdata) latch_ok = 1'b0;
            @(posedge clk); #1;
            if (rsp_valid) begin lat = k; fin = 1'b1; end
        end
        check({name, "_lat"}, lat, wr ? WLAT : RLAT);
        check({name, "_wrcyc"}, wr_cyc, wr ? 1 : 0);
        check({name, "_latched"}, latch_ok, 1'b1);
        if (!wr) last_rd = exp_rdata;
        check({name, "_rdata"}, rsp_rdata, last_rd);
        check({name, "_err"}, rsp_err, exp_err);
        check({name, "_cs_idle"}, mem_cs, 1'b0);
        check({name, "_rdy_rsp"}, req_ready, 1'b1);
        @(posedge clk); #1;
        check({name, "_pulse"}, rsp_valid, 1'b0);
    endtask

    typedef struct {
        req_t       req;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{req: '{wr: 1'b1, addr: 10'h005, wdata: 8'hA5}, exp_rdata: 8'h00};
        vecs[1] = '{req: '{wr: 1'b0, addr: 10'h005, wdata: 8'h00}, exp_rdata: 8'hA5};
        vecs[2] = '{req: '{wr: 1'b1, addr: 10'h010, wdata: 8'h3C}, exp_rdata: 8'h00};
        vecs[3] = '{req: '{wr: 1'b1, addr: 10'h100, wdata: 8'hAA}, exp_rdata: 8'h00};
        vecs[4] = '{req: '{wr: 1'b0, addr: 10'h010, wdata: 8'hFF}, exp_rdata: 8'h3C};
        vecs[5] = '{req: '{wr: 1'b0, addr: 10'h100, wdata: 8'h00}, exp_rdata: 8'hAA};
        vecs[6] = '{req: '{wr: 1'b1, addr: 10'h005, wdata: 8'h5A}, exp_rdata: 8'h00};

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", mem_cs, 1'b0);
        check("rst_wr", mem_wr, 1'b0);
        check("rst_addr", mem_addr, 10'h000);
        check("rst_din", mem_din, 8'h00);
        check("rst_rsp", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 8'h00);
        check("rst_err", rsp_err, 1'b0);
        check("rst_errcnt", err_cnt, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", req_ready, 1'b1);

        foreach (vecs[i])
            do_req($sformatf("vec%0d", i), vecs[i].req.wr, vecs[i].req.addr,
                   vecs[i].req.wdata, vecs[i].exp_rdata, 1'b0);

        // Back-to-back writes with req_valid held high.
        begin
            logic [9:0] b_addr [3];
            logic [7:0] b_data [3];
            int idx = 0;
            int cyc = 0;
            logic acc;
            b_addr[0] = 10'h3FF; b_addr[1] = 10'h000; b_addr[2] = 10'h200;
            b_data[0] = 8'h11;   b_data[1] = 8'h22;   b_data[2] = 8'h33;
            req_valid = 1'b1; req_wr = 1'b1; req_addr = b_addr[0]; req_wdata = b_data[0];
            while (idx < 3 && cyc < 100) begin
                acc = req_ready;
                if (rsp_valid) begin
                    check("b2b_cs_gap", mem_cs, 1'b0);
                    check("b2b_ready", req_ready, 1'b1);
                end
                @(posedge clk); #1; cyc++;
                if (acc) begin
                    check("b2b_cs_up", mem_cs, 1'b1);
                    idx++;
                    if (idx < 3) begin
                        req_addr = b_addr[idx]; req_wdata = b_data[idx];
                    end
                end
            end
            req_valid = 1'b0;
            check("b2b_accepts", idx, 3);
            cyc = 0;
            while (!rsp_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
            check("b2b_last_rsp", rsp_valid, 1'b1);
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                do_req($sformatf("b2b_rd%0d", i), 1'b0, b_addr[i], 8'h00, b_data[i], 1'b0);
        end

        // Reset while a write of 0x77 to 0x010 sits in SETUP.
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h010; req_wdata = 8'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_setup_cs", mem_cs, 1'b1);
        check("abort_setup_wr", mem_wr, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_cs", mem_cs, 1'b0);
        check("abort_wr", mem_wr, 1'b0);
        check("abort_addr", mem_addr, 10'h000);
        check("abort_din", mem_din, 8'h00);
        check("abort_rsp", rsp_valid, 1'b0);
        check("abort_rdata", rsp_rdata, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rd = 8'h00;
        @(posedge clk); #1;
        check("abort_ready", req_ready, 1'b1);
        do_req("abort_rd", 1'b0, 10'h010, 8'h00, 8'h3C, 1'b0);

`ifdef MEM_CTRL_VERIFY_EN
        wmask = 8'hFE;
        do_req("vfy_first", 1'b1, 10'h020, 8'h01, 8'h00, 1'b1);
        check("vfy_cnt1", err_cnt, 8'h01);
        do_req("vfy_clean", 1'b1, 10'h021, 8'h02, 8'h00, 1'b0);
        check("vfy_cnt_clean", err_cnt, 8'h01);
        for (int i = 0; i < 299; i++)
            do_req("vfy_rep", 1'b1, 10'h020, 8'h01, 8'h00, 1'b1);
        check("vfy_sat", err_cnt, 8'hFF);
        wmask = 8'hFF;
`else
        check("errcnt_tied", err_cnt, 8'h00);
`endif

        check("strobe_order", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
